// File: rtl/ext_pkg.sv
// Immediate-extension modes and the shared extension function used by both the
// pipelined extender and the single-cycle datapath.
package ext_pkg;

    localparam logic [2:0] EXT_ZERO   = 3'd0;
    localparam logic [2:0] EXT_SIGN   = 3'd1;
    localparam logic [2:0] EXT_UPPER  = 3'd2;
    localparam logic [2:0] EXT_BRANCH = 3'd3;
    localparam logic [2:0] EXT_ONES   = 3'd4;

    // Widest result the generic function can produce (keeps 64-bit shifts well defined).
    localparam int EXT_MAX_W = 62;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    // Returns {err, data}; data is masked to out_w bits, upper bits are always zero.
    function automatic logic [64:0] ext_apply(input logic [63:0] imm,
                                              input logic [2:0]  mode,
                                              input int          in_w,
                                              input int          out_w);
        logic [63:0] mask_in;
        logic [63:0] mask_out;
        logic [63:0] imm_m;
        logic [63:0] sext;
        logic [63:0] data;
        logic        err;
        mask_in  = (64'd1 << in_w) - 64'd1;
        mask_out = (64'd1 << out_w) - 64'd1;
        imm_m    = imm & mask_in;
        sext     = (|(imm & (64'd1 << (in_w - 1)))) ? (imm_m | ~mask_in) : imm_m;
        err      = 1'b0;
        case (mode)
            EXT_ZERO:   data = imm_m;
            EXT_SIGN:   data = sext;
            EXT_UPPER:  data = imm_m << (out_w - in_w);
            EXT_BRANCH: data = sext << 2;
            EXT_ONES:   data = imm_m | ~mask_in;
            default: begin
                data = 64'd0;
                err  = 1'b1;
            end
        endcase
        return {err, data & mask_out};
    endfunction

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Valid/ready bus into and out of the pipelined immediate extender.
interface imm_ext_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [2:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_err;

    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/imm_ext_pipe_skid_buf2.sv
// Two-entry valid/ready FIFO (head + skid) with synchronous flush; all outputs
// come straight from flops.
module skid_buf2
    import ext_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_t   state_p1, state_n;
    logic [W-1:0] head_p1, head_n;
    logic [W-1:0] skid_p1, skid_n;
    logic         vld_p1;
    logic         rdy_p1;
    logic         push;
    logic         pop;

    assign push = in_valid && rdy_p1;
    assign pop  = vld_p1 && out_ready;

    always_comb begin
        state_n = state_p1;
        head_n  = head_p1;
        skid_n  = skid_p1;
        if (flush) begin
            state_n = BUF_EMPTY;
        end else begin
            case (state_p1)
                BUF_EMPTY: begin
                    if (push) begin
                        head_n  = in_data;
                        state_n = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    // Drain and refill together: the new entry becomes the head.
                    if (push && pop) begin
                        head_n = in_data;
                    end else if (push) begin
                        skid_n  = in_data;
                        state_n = BUF_FULL;
                    end else if (pop) begin
                        state_n = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (pop) begin
                        head_n  = skid_p1;
                        state_n = BUF_ONE;
                    end
                end
                default: state_n = BUF_EMPTY;
            endcase
        end
    end

    // ---- stage p1: buffer registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1 <= BUF_EMPTY;
            head_p1  <= '0;
            skid_p1  <= '0;
            vld_p1   <= 1'b0;
            rdy_p1   <= 1'b1;
        end else begin
            state_p1 <= state_n;
            head_p1  <= head_n;
            skid_p1  <= skid_n;
            vld_p1   <= (state_n != BUF_EMPTY);
            rdy_p1   <= (state_n != BUF_FULL);
        end
    end

    assign in_ready  = rdy_p1;
    assign out_valid = vld_p1;
    assign out_data  = head_p1;

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined mode-selectable immediate extender: extension on the input side,
// result and error flag queued in a two-entry skid buffer.
module imm_ext_pipe
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    imm_ext_pipe_if.slave      bus
);

    logic [64:0]  ext_p0;
    logic [OUT_W:0] payload_p0;
    logic [OUT_W:0] payload_p1;
    logic         unused_hi;

    // ---- stage p0: combinational extension of the accepted immediate ----
    assign ext_p0     = ext_apply(64'(bus.in_imm), bus.in_mode, IN_W, OUT_W);
    assign payload_p0 = {ext_p0[64], ext_p0[OUT_W-1:0]};
    assign unused_hi  = ^ext_p0[63:OUT_W];

    skid_buf2 #(
        .W (OUT_W + 1)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (payload_p0),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (payload_p1)
    );

    // ---- stage p1: registered result ----
    assign bus.out_err  = payload_p1[OUT_W];
    assign bus.out_data = payload_p1[OUT_W-1:0];

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: a 16->32 instance plus an 8->16 instance.
module tb_imm_ext_pipe;
    import ext_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic flush8;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    imm_ext_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();
    imm_ext_pipe_if #(.IN_W(8),  .OUT_W(16)) bus8 ();

    imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    imm_ext_pipe #(.IN_W(8), .OUT_W(16)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush8),
        .bus   (bus8.slave)
    );

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_imm = 16'h5555; bus.in_mode = EXT_SIGN; bus.out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid c%0d got %b want 0", c, bus.out_valid); end
            n_cmp++; if (bus.out_data !== 32'h0) begin n_bad++; $display("FAIL reset_out_data c%0d got %h want 0", c, bus.out_data); end
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready c%0d got %b want 1", c, bus.in_ready); end
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_modes();
        logic [31:0] exp_tab [5];
        exp_tab[0] = 32'h00008001; exp_tab[1] = 32'hFFFF8001; exp_tab[2] = 32'h80010000;
        exp_tab[3] = 32'hFFFE0004; exp_tab[4] = 32'hFFFF8001;
        bus.out_ready = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) begin
                n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_tab[k-1] || bus.out_err !== 1'b0) begin
                    n_bad++; $display("FAIL mode%0d got v=%b d=%h e=%b want v=1 d=%h e=0", k-1, bus.out_valid, bus.out_data, bus.out_err, exp_tab[k-1]);
                end
            end
            if (k < 5) begin
                bus.in_valid = 1'b1; bus.in_imm = 16'h8001; bus.in_mode = 3'(k);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL modes_drain got v=%b want 0", bus.out_valid); end
    endtask

    task automatic test_illegal();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_imm = 16'h1234; bus.in_mode = 3'd7;
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0 || bus.out_err !== 1'b1) begin
            n_bad++; $display("FAIL illegal got v=%b d=%h e=%b want v=1 d=0 e=1", bus.out_valid, bus.out_data, bus.out_err);
        end
        bus.in_mode = EXT_SIGN;
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00001234 || bus.out_err !== 1'b0) begin
            n_bad++; $display("FAIL after_illegal got v=%b d=%h e=%b want v=1 d=00001234 e=0", bus.out_valid, bus.out_data, bus.out_err);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic [31:0] got [$];
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_mode = EXT_SIGN; bus.in_imm = 16'h0001;
        @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_ready1 got %b want 1", bus.in_ready); end
        bus.in_imm = 16'h0002;
        @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_full got %b want 0", bus.in_ready); end
        bus.in_imm = 16'h0003;
        @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 32'h1) begin
            n_bad++; $display("FAIL stall_hold got r=%b v=%b d=%h want r=0 v=1 d=00000001", bus.in_ready, bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (bus.out_valid === 1'b1) got.push_back(bus.out_data);
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        n_cmp++; if (got.size() != 3) begin n_bad++; $display("FAIL stall_count got %0d want 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i >= got.size()) begin n_bad++; $display("FAIL stall_item%0d got none want %h", i, 32'(i + 1)); end
            else if (got[i] !== 32'(i + 1)) begin n_bad++; $display("FAIL stall_item%0d got %h want %h", i, got[i], 32'(i + 1)); end
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_mode = EXT_ZERO; bus.in_imm = 16'h00AA;
        @(negedge clk);
        bus.in_imm = 16'h00BB;
        @(negedge clk);
        bus.in_imm = 16'h0CCC; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL flush_full got v=%b r=%b want v=0 r=1", bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_leak c%0d got v=%b d=%h want v=0", c, bus.out_valid, bus.out_data); end
        end
        // Flush with room available: the concurrent input must still be dropped.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_imm = 16'h00DD;
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h000000DD) begin
            n_bad++; $display("FAIL flush_prep got v=%b d=%h want v=1 d=000000dd", bus.out_valid, bus.out_data);
        end
        bus.in_imm = 16'h00EE; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL flush_one got v=%b r=%b want v=0 r=1", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_one_leak got v=%b d=%h want v=0", bus.out_valid, bus.out_data); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_mode = EXT_ONES; bus.in_imm = 16'h00F0;
        @(negedge clk);
        bus.in_mode = 3'd6;
        @(negedge clk);
        rst = 1'b1; flush = 1'b1;
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_err !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_mid got v=%b d=%h e=%b r=%b want v=0 d=0 e=0 r=1", bus.out_valid, bus.out_data, bus.out_err, bus.in_ready);
        end
    endtask

    task automatic test_param();
        bus8.out_ready = 1'b1;
        bus8.in_valid = 1'b1; bus8.in_imm = 8'hF0; bus8.in_mode = EXT_BRANCH;
        @(negedge clk);
        n_cmp++; if (bus8.out_valid !== 1'b1 || bus8.out_data !== 16'hFFC0 || bus8.out_err !== 1'b0) begin
            n_bad++; $display("FAIL param_branch got v=%b d=%h e=%b want v=1 d=ffc0 e=0", bus8.out_valid, bus8.out_data, bus8.out_err);
        end
        bus8.in_mode = EXT_UPPER;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        n_cmp++; if (bus8.out_valid !== 1'b1 || bus8.out_data !== 16'hF000) begin
            n_bad++; $display("FAIL param_upper got v=%b d=%h want v=1 d=f000", bus8.out_valid, bus8.out_data);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; flush8 = 1'b0;
        bus.in_valid = 1'b0; bus.in_imm = '0; bus.in_mode = '0; bus.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.in_imm = '0; bus8.in_mode = '0; bus8.out_ready = 1'b0;
        test_reset();
        test_modes();
        test_illegal();
        test_stall();
        test_flush();
        test_reset_mid();
        test_param();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
